// File: rtl/strobe_interval_meter.sv
// strobe_interval_meter
// Counts enable ticks between successive strobe pulses and reports each
// completed interval through a single-entry valid/ready output register.
// The tick counter saturates at all-ones; a saturated interval is flagged
// with overflow. Results arriving while the output register is full and
// not being drained are discarded and recorded in the sticky dropped flag.

module strobe_interval_meter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             strobe,
    input  logic             ready,
    output logic [WIDTH-1:0] interval,
    output logic             valid,
    output logic             overflow,
    output logic             dropped,
    output logic             armed
);

    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    // Saturating increment: adds one when inc is set unless already at all-ones.
    function automatic logic [WIDTH-1:0] sat_inc(
        input logic [WIDTH-1:0] val,
        input logic             inc
    );
        logic [WIDTH-1:0] step;
        step = {{(WIDTH-1){1'b0}}, 1'b1};
        if (inc && (val != CNT_MAX)) begin
            sat_inc = val + step;
        end else begin
            sat_inc = val;
        end
    endfunction

    // Measurement state
    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] cnt_s;
    logic             ovf_r;
    logic             ovf_s;

    // Result produced this cycle
    logic [WIDTH-1:0] sum_s;
    logic             sat_s;
    logic             result_s;
    logic             result_ovf_s;

    // Output register
    logic [WIDTH-1:0] interval_r;
    logic [WIDTH-1:0] interval_s;
    logic             overflow_r;
    logic             overflow_s;
    logic             valid_r;
    logic             valid_s;
    logic             dropped_r;
    logic             dropped_s;
    logic             accept_s;
    logic             discard_s;
    logic             load_s;

    // Next-state, counter update and result generation for the measurement FSM.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        ovf_s        = ovf_r;
        result_s     = 1'b0;
        result_ovf_s = 1'b0;
        // The strobe cycle's own enable tick belongs to the interval it ends.
        sum_s        = sat_inc(cnt_r, enable);
        sat_s        = (sum_s == CNT_MAX);

        case (state_r)
            ST_IDLE: begin
                // Arming strobe: its enable tick is not counted.
                cnt_s = CNT_ZERO;
                ovf_s = 1'b0;
                if (strobe) begin
                    state_s = ST_MEASURE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEASURE: begin
                state_s = ST_MEASURE;
                if (strobe) begin
                    // End the current interval and start the next in one cycle.
                    result_s     = 1'b1;
                    result_ovf_s = ovf_r | sat_s;
                    cnt_s        = CNT_ZERO;
                    ovf_s        = 1'b0;
                end else begin
                    cnt_s = sum_s;
                    ovf_s = ovf_r | sat_s;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                ovf_s   = 1'b0;
            end
        endcase
    end

    // State register for the FSM, tick counter and saturation flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ovf_r   <= ovf_s;
        end
    end

    // Output register control: load, drain, discard and sticky drop tracking.
    always_comb begin
        interval_s = interval_r;
        overflow_s = overflow_r;
        valid_s    = valid_r;
        dropped_s  = dropped_r;

        accept_s  = valid_r & ready;
        // A full register that is not draining this cycle rejects new results.
        discard_s = result_s & valid_r & ~ready;
        load_s    = result_s & ~discard_s;

        if (load_s) begin
            interval_s = sum_s;
            overflow_s = result_ovf_s;
            valid_s    = 1'b1;
        end else if (accept_s) begin
            valid_s = 1'b0;
        end else begin
            valid_s = valid_r;
        end

        if (discard_s) begin
            dropped_s = 1'b1;
        end else if (accept_s) begin
            dropped_s = 1'b0;
        end else begin
            dropped_s = dropped_r;
        end
    end

    // Output register storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            interval_r <= CNT_ZERO;
            overflow_r <= 1'b0;
            valid_r    <= 1'b0;
            dropped_r  <= 1'b0;
        end else begin
            interval_r <= interval_s;
            overflow_r <= overflow_s;
            valid_r    <= valid_s;
            dropped_r  <= dropped_s;
        end
    end

    assign interval = interval_r;
    assign overflow = overflow_r;
    assign valid    = valid_r;
    assign dropped  = dropped_r;
    assign armed    = (state_r == ST_MEASURE);

endmodule

// File: tb/tb_strobe_interval_meter.sv
// Testbench for strobe_interval_meter (WIDTH=4 so saturation is reachable).
// A behavioural model tracks unbounded tick totals and clamps them when a
// result is reported; a compare process checks every output on each falling
// edge. Directed scenarios add hand-computed literal checks, then a random
// phase exercises strobes, backpressure and asynchronous resets.

module tb_strobe_interval_meter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         strobe;
    logic         ready;
    logic [W-1:0] interval;
    logic         valid;
    logic         overflow;
    logic         dropped;
    logic         armed;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit m_armed    = 1'b0;
    int m_ticks    = 0;
    bit m_valid    = 1'b0;
    int m_interval = 0;
    bit m_ovf      = 1'b0;
    bit m_drop     = 1'b0;

    strobe_interval_meter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .strobe   (strobe),
        .ready    (ready),
        .interval (interval),
        .valid    (valid),
        .overflow (overflow),
        .dropped  (dropped),
        .armed    (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ticks accumulate as plain integers; a report is min(total, MAX).
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_armed = 1'b0; m_ticks = 0; m_valid = 1'b0;
            m_interval = 0; m_ovf = 1'b0; m_drop = 1'b0;
        end else begin
            bit have;
            int total;
            bit was_full;
            have     = 1'b0;
            total    = 0;
            was_full = m_valid;
            if (strobe && m_armed) begin
                have    = 1'b1;
                total   = m_ticks + int'(enable);
                m_ticks = 0;
            end else if (strobe) begin
                m_armed = 1'b1;
            end else if (m_armed) begin
                m_ticks = m_ticks + int'(enable);
            end
            if (have && was_full && !ready) begin
                m_drop = 1'b1;
            end else begin
                if (was_full && ready) m_drop = 1'b0;
                if (have) begin
                    m_interval = (total > MAXV) ? MAXV : total;
                    m_ovf      = (total >= MAXV);
                    m_valid    = 1'b1;
                end else if (was_full && ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        chk("valid",    int'(valid),    int'(m_valid));
        chk("interval", int'(interval), m_interval);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("dropped",  int'(dropped),  int'(m_drop));
        chk("armed",    int'(armed),    int'(m_armed));
    end

    // Apply inputs for one clock and return shortly after the sampling edge.
    task automatic step(input logic en, input logic st, input logic rd);
        enable = en;
        strobe = st;
        ready  = rd;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0; enable = 1'b0; strobe = 1'b0; ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_valid", int'(valid), 0);
        chk("reset_armed", int'(armed), 0);
        rst = 1'b1;

        // Continuous count: arming strobe, then 5 ticks including the strobe cycle
        step(1'b1, 1'b1, 1'b1);
        chk("t1_armed", int'(armed), 1);
        chk("t1_noresult", int'(valid), 0);
        repeat (4) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("t1_valid", int'(valid), 1);
        chk("t1_interval", int'(interval), 5);
        chk("t1_ovf", int'(overflow), 0);
        step(1'b1, 1'b0, 1'b1);
        chk("t1_drain", int'(valid), 0);

        // Gated ticks: 0,1,0,1,0,1,0 between strobes plus enable on the strobe
        step(1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 7; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("t2_interval", int'(interval), 4);
        step(1'b0, 1'b1, 1'b1);
        chk("t2_zero_valid", int'(valid), 1);
        chk("t2_zero", int'(interval), 0);
        chk("t2_zero_ovf", int'(overflow), 0);

        // Saturation: 20 ticks clamp to 15 with overflow, then a clean 6
        step(1'b1, 1'b1, 1'b1);
        repeat (19) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("t3_sat", int'(interval), 15);
        chk("t3_ovf", int'(overflow), 1);
        repeat (5) step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("t3_six", int'(interval), 6);
        chk("t3_six_ovf", int'(overflow), 0);

        // Backpressure: intervals 3, 7, 2 with ready low
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_first", int'(interval), 3);
        repeat (6) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_held", int'(interval), 3);
        chk("t4_dropped", int'(dropped), 1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t4_held2", int'(interval), 3);
        step(1'b0, 1'b0, 1'b1);
        chk("t4_drain", int'(valid), 0);
        chk("t4_drop_clr", int'(dropped), 0);

        // Back-to-back accept: valid with 3 while a 9-tick interval ends
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t5_pre", int'(interval), 3);
        repeat (8) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("t5_valid", int'(valid), 1);
        chk("t5_interval", int'(interval), 9);
        chk("t5_dropped", int'(dropped), 0);

        // Async reset mid-measure, between clock edges
        repeat (6) step(1'b1, 1'b0, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("t6_valid", int'(valid), 0);
        chk("t6_interval", int'(interval), 0);
        chk("t6_armed", int'(armed), 0);
        chk("t6_dropped", int'(dropped), 0);
        @(posedge clk);
        #2 rst = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        chk("t6_rearm", int'(armed), 1);
        chk("t6_noresult", int'(valid), 0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("t6_interval4", int'(interval), 4);

        // Random phase
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b0;
                @(posedge clk);
                #2 rst = 1'b1;
            end else begin
                step(1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 2) == 0));
            end
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/strobe_interval_meter.md
Name: strobe_interval_meter

Overview:
- Measures the number of enable ticks between successive strobe pulses; the receiving-side counterpart of the strobe-generating counter.
- Reports each measured interval through a valid/ready output register.
- Sits downstream of any strobe source to check divider ratios, time events, or recover a programmed reset_value.

Parameters:
WIDTH, 16, width of the tick counter and of the reported interval.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  reset, asynchronous, active-low: rst=0 clears all state immediately.
enable  input  1  tick qualifier; each cycle with enable=1 counts one tick.
strobe  input  1  event pulse; each cycle with strobe=1 is one event. Multi-cycle highs count as one event per cycle.
interval  output  WIDTH  measured tick count of the last completed interval.
valid  output  1  interval/overflow hold an unaccepted result.
ready  input  1  consumer accepts the result when valid&&ready at a rising edge.
overflow  output  1  the reported interval saturated.
dropped  output  1  sticky: at least one result was discarded because the output register was full.
armed  output  1  first strobe since reset has been seen; measurement in progress.

Behaviour:
- Reset (rst=0, async): all outputs are 0, including interval. The tick counter is 0, the saturation flag is 0, and the state is IDLE. Release is sampled synchronously at the next clk edge.
- States:
  - IDLE: the counter is held at 0 and armed=0.
  - MEASURE: armed=1.
  - IDLE -> MEASURE on strobe. That first strobe produces no result.
  - MEASURE has no exit except reset.
- Counting in MEASURE:
  - cnt_next = cnt + enable, saturating at 2^WIDTH-1. Reaching saturation sets the internal ovf flag.
  - On a strobe cycle in MEASURE, the result is sum = sat(cnt + enable). The enable of the strobe cycle belongs to the ending interval.
  - Also on that cycle: result_ovf = ovf OR (saturation reached on this increment). The counter and ovf then restart at 0, so the strobe both ends one interval and begins the next.
  - The enable tick of the arming strobe in IDLE is not counted.
- Zero interval: strobes on consecutive cycles with enable=0 between and on the second -> interval=0, overflow=0.
- Output register:
  - The result loads at the rising edge that samples the strobe. interval, overflow and valid=1 are visible the next cycle, a latency of 1 clk.
  - valid&&ready with no new result -> valid=0 next cycle; interval/overflow hold their last values.
  - New result while valid=0 -> load.
  - New result while valid=1 and ready=1 in the same cycle -> load; valid stays 1 and the new value replaces the old with no bubble.
  - New result while valid=1 and ready=0 -> the new result is discarded, the old result is held unchanged, and dropped=1.
- dropped clears on the cycle after any valid&&ready transfer, unless a discard occurs in that same cycle; in that case it stays 1.
- Simultaneous strobe with enable at saturation: the saturated count is reported with overflow=1.
- Reset mid-operation:
  - The pending result, dropped and armed are all lost.
  - After release, the first strobe only re-arms and produces no result.
- ready is ignored while valid=0. Inputs are assumed synchronous to clk.
- Arithmetic:
  - The counter is WIDTH bits wide with no wrap-around. It saturates and holds at all-ones.
  - interval is zero-extended from the counter with no width change.

Test Plan:
1. Continuous count: rst released; enable=1 constant; ready=1; strobe at cycles 10 and 15.
   -> No result after the cycle-10 strobe; armed=1 from cycle 11.
   -> At cycle 16: valid=1, interval=5, overflow=0.
   -> At cycle 17: valid=0.
2. Gated ticks: enable alternating 1,0; strobes 8 cycles apart, enable=1 on the second strobe cycle.
   -> interval=4. A further strobe on the very next cycle with enable=0 -> interval=0.
3. Saturation: WIDTH=4, enable=1; 20 cycles between strobes.
   -> interval=15, overflow=1.
   -> The next 6-cycle interval reports interval=6, overflow=0.
4. Backpressure: ready=0; three intervals of 3, 7 and 2 ticks complete.
   -> interval=3 is held; dropped=1 after the second result.
   -> Raise ready for one cycle -> valid=0, and dropped=0 on the following cycle.
5. Back-to-back accept: valid=1 (interval=3); ready=1 and strobe ending a 9-tick interval on the same cycle.
   -> The next cycle shows valid=1, interval=9, dropped=0.
6. Async reset mid-measure: drop rst between clk edges while cnt=6 and valid=1.
   -> valid, interval, armed and dropped go to 0 immediately, with no clk edge needed.
   -> After release, a strobe only arms; the next strobe after 4 enables reports interval=4.
